// File: rtl/galvo_scan_seq.sv
// Galvo raster scan sequencer: steps the mirror pixel by pixel,
// issuing an SPI position write and a settle delay before each sample.
module galvo_scan_seq #(
  parameter int POS_W    = 11,
  parameter int SETTLE_W = 8
) (
  input  logic                clk_adc,
  input  logic                rst_adc,
  input  logic                start,
  input  logic                halt,
  input  logic                continuous,
  input  logic [POS_W-1:0]    h_size,
  input  logic [POS_W-1:0]    v_size,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                galvo_go,
  input  logic                galvo_spi_done,
  output logic [POS_W-1:0]    galvoh,
  output logic [POS_W-1:0]    galvov,
  output logic                spi_start,
  output logic                settled,
  output logic                busy,
  output logic                line_done,
  output logic                frame_done,
  output logic                overrun,
  output logic [1:0]          scan_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPI    = 2'd1,
    S_SETTLE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    h_q, h_d;
  logic [POS_W-1:0]    v_q, v_d;
  logic [POS_W-1:0]    h_last_q, h_last_d;
  logic [POS_W-1:0]    v_last_q, v_last_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                spi_q, spi_d;
  logic                ld_q, ld_d;
  logic                fd_q, fd_d;
  logic                ovr_q, ovr_d;

  logic [POS_W-1:0] h_last_in;
  logic [POS_W-1:0] v_last_in;

  // a zero size scans as a single pixel
  assign h_last_in = (h_size == '0) ? '0 : h_size - POS_W'(1);
  assign v_last_in = (v_size == '0) ? '0 : v_size - POS_W'(1);

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    h_last_d = h_last_q;
    v_last_d = v_last_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    spi_d    = 1'b0;
    ld_d     = 1'b0;
    fd_d     = 1'b0;
    ovr_d    = ovr_q;
    if (halt) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            h_last_d = h_last_in;
            v_last_d = v_last_in;
            settle_d = settle_cycles;
            h_d      = '0;
            v_d      = '0;
            spi_d    = 1'b1;
            ovr_d    = 1'b0;
            state_d  = S_SPI;
          end
        end
        S_SPI: begin
          if (galvo_go) ovr_d = 1'b1;
          if (galvo_spi_done) begin
            cnt_d   = settle_q;
            state_d = (settle_q == '0) ? S_WAIT : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (galvo_go) ovr_d = 1'b1;
          if (cnt_q <= SETTLE_W'(1)) begin
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q - SETTLE_W'(1);
          end
        end
        S_WAIT: begin
          if (galvo_go) begin
            if (h_q < h_last_q) begin
              h_d     = h_q + POS_W'(1);
              spi_d   = 1'b1;
              state_d = S_SPI;
            end else if (v_q < v_last_q) begin
              h_d     = '0;
              v_d     = v_q + POS_W'(1);
              ld_d    = 1'b1;
              spi_d   = 1'b1;
              state_d = S_SPI;
            end else begin
              h_d     = '0;
              v_d     = '0;
              ld_d    = 1'b1;
              fd_d    = 1'b1;
              spi_d   = continuous;
              state_d = continuous ? S_SPI : S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_adc or posedge rst_adc) begin
    if (rst_adc) begin
      state_q  <= S_IDLE;
      h_q      <= '0;
      v_q      <= '0;
      h_last_q <= '0;
      v_last_q <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      spi_q    <= 1'b0;
      ld_q     <= 1'b0;
      fd_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      h_last_q <= h_last_d;
      v_last_q <= v_last_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      spi_q    <= spi_d;
      ld_q     <= ld_d;
      fd_q     <= fd_d;
      ovr_q    <= ovr_d;
    end
  end

  assign galvoh     = h_q;
  assign galvov     = v_q;
  assign spi_start  = spi_q;
  assign line_done  = ld_q;
  assign frame_done = fd_q;
  assign overrun    = ovr_q;
  assign settled    = (state_q == S_WAIT);
  assign busy       = (state_q != S_IDLE);
  assign scan_state = state_q;

endmodule

// File: tb/tb_galvo_scan_seq.sv
// Bench for galvo_scan_seq: pixel-index reference model plus
// directed timing cases and a randomized scan phase.
module tb_galvo_scan_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        cont = 1'b0;
  logic [10:0] h_size = '0;
  logic [10:0] v_size = '0;
  logic [7:0]  settle = '0;
  logic        galvo_go = 1'b0;
  logic        spi_done = 1'b0;
  logic [10:0] galvoh, galvov;
  logic        spi_start, settled, busy;
  logic        line_done, frame_done, overrun;
  logic [1:0]  scan_state;

  galvo_scan_seq dut (
    .clk_adc       (clk),
    .rst_adc       (rst),
    .start         (start),
    .halt          (halt),
    .continuous    (cont),
    .h_size        (h_size),
    .v_size        (v_size),
    .settle_cycles (settle),
    .galvo_go      (galvo_go),
    .galvo_spi_done(spi_done),
    .galvoh        (galvoh),
    .galvov        (galvov),
    .spi_start     (spi_start),
    .settled       (settled),
    .busy          (busy),
    .line_done     (line_done),
    .frame_done    (frame_done),
    .overrun       (overrun),
    .scan_state    (scan_state)
  );

  always #5 clk = ~clk;

  // reference: mode uses the published scan_state codes,
  // position advances as a linear pixel index
  int m_mode, m_h, m_v, m_hl, m_vl, m_st, m_left;
  int m_spi, m_ld, m_fd, m_ovr;

  always @(posedge clk or posedge rst) begin
    int idx, nv, w;
    if (rst) begin
      m_mode = 0; m_h = 0; m_v = 0; m_hl = 0; m_vl = 0;
      m_st = 0; m_left = 0; m_spi = 0; m_ld = 0;
      m_fd = 0; m_ovr = 0;
    end else begin
      m_spi = 0; m_ld = 0; m_fd = 0;
      if (halt) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (start) begin
          m_hl = (h_size == 0) ? 0 : int'(h_size) - 1;
          m_vl = (v_size == 0) ? 0 : int'(v_size) - 1;
          m_st = int'(settle);
          m_h = 0; m_v = 0; m_spi = 1; m_ovr = 0;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (galvo_go) m_ovr = 1;
        if (spi_done) begin
          m_left = m_st;
          m_mode = (m_st == 0) ? 3 : 2;
        end
      end else if (m_mode == 2) begin
        if (galvo_go) m_ovr = 1;
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 3;
      end else if (galvo_go) begin
        w = m_hl + 1;
        idx = m_v * w + m_h + 1;
        if (idx == w * (m_vl + 1)) begin
          m_h = 0; m_v = 0; m_ld = 1; m_fd = 1;
          m_spi = cont ? 1 : 0;
          m_mode = cont ? 1 : 0;
        end else begin
          nv = idx / w;
          m_ld = (nv != m_v) ? 1 : 0;
          m_h = idx % w;
          m_v = nv;
          m_spi = 1;
          m_mode = 1;
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int n_spi, n_ld, n_fd, max_h;
  int pos_q[$];
  int auto_en = 0;
  int dt = 0, gt = 0, prev_mode = 0;
  int done_dly = 5, go_dly = 2;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // one cycle: new inputs are applied on the falling edge
  task automatic tick();
    @(negedge clk);
    start = 0; halt = 0; galvo_go = 0; spi_done = 0;
    if (auto_en != 0) begin
      if (dt > 0) begin
        dt--;
        if (dt == 0) spi_done = 1;
      end
      if (m_spi != 0) dt = done_dly;
      if (gt > 0) begin
        gt--;
        if (gt == 0) galvo_go = 1;
      end
      if (m_mode == 3 && prev_mode != 3) gt = go_dly;
    end
    prev_mode = m_mode;
  endtask

  task automatic clr_cnt();
    n_spi = 0; n_ld = 0; n_fd = 0; max_h = 0;
    pos_q.delete();
  endtask

  task automatic to_idle();
    auto_en = 0; dt = 0; gt = 0;
    tick(); halt = 1;
    tick();
  endtask

  task automatic setup(int h, int v, int s, int c);
    h_size = 11'(h); v_size = 11'(v);
    settle = 8'(s); cont = c[0];
  endtask

  task automatic run_frame(string nm);
    tick(); start = 1;
    tick();
    for (int i = 0; i < 500 && busy; i++) tick();
    chk({nm, "_timeout"}, int'(busy), 0);
  endtask

  initial begin
    int k;
    int exp_pos[6];
    exp_pos = '{0, 100, 200, 1, 101, 201};
    clr_cnt();
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk("galvoh", int'(galvoh), m_h);
          chk("galvov", int'(galvov), m_v);
          chk("spi_start", int'(spi_start), m_spi);
          chk("line_done", int'(line_done), m_ld);
          chk("frame_done", int'(frame_done), m_fd);
          chk("overrun", int'(overrun), m_ovr);
          chk("scan_state", int'(scan_state), m_mode);
          chk("settled", int'(settled), int'(m_mode == 3));
          chk("busy", int'(busy), int'(m_mode != 0));
          if (spi_start)
            pos_q.push_back(int'(galvoh) * 100 + int'(galvov));
          if (spi_start) n_spi++;
          if (line_done) n_ld++;
          if (frame_done) n_fd++;
          if (int'(galvoh) > max_h) max_h = int'(galvoh);
        end
      end
    join_none

    #12;
    chk("rst_state", int'(scan_state), 0);
    chk("rst_outs", int'({galvoh, galvov, spi_start, settled,
        busy, line_done, frame_done, overrun}), 0);
    @(negedge clk); rst = 0;

    // 3x2 frame, settle 4, done +5, go +2
    setup(3, 2, 4, 0);
    done_dly = 5; go_dly = 2;
    to_idle(); clr_cnt(); auto_en = 1;
    run_frame("frame32");
    chk("f32_spi", n_spi, 6);
    chk("f32_ld", n_ld, 2);
    chk("f32_fd", n_fd, 1);
    chk("f32_idle", int'(scan_state), 0);
    chk("f32_npos", pos_q.size(), 6);
    for (int i = 0; i < 6 && i < pos_q.size(); i++)
      chk("f32_pos", pos_q[i], exp_pos[i]);

    // settle latency from the done pulse
    for (int s = 0; s <= 4; s += 4) begin
      setup(3, 2, s, 0);
      to_idle();
      tick(); start = 1;
      tick(); spi_done = 1;
      k = 0;
      do begin tick(); k++; end while (!settled && k < 20);
      chk(s == 0 ? "settle0_lat" : "settle4_lat", k, s + 1);
    end

    // go during SETTLE sets overrun, next start clears it
    setup(3, 2, 4, 0);
    to_idle();
    tick(); start = 1;
    tick(); spi_done = 1;
    tick(); galvo_go = 1;
    tick();
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_hold_h", int'(galvoh), 0);
    halt = 1;
    tick(); start = 1;
    tick();
    chk("ovr_clr", int'(overrun), 0);

    // halt beats galvo_go in WAIT_GO at (1,0)
    setup(3, 2, 0, 0);
    to_idle();
    tick(); start = 1;
    tick(); spi_done = 1;
    tick(); galvo_go = 1;
    tick(); spi_done = 1;
    tick(); galvo_go = 1; halt = 1;
    tick();
    chk("halt_state", int'(scan_state), 0);
    chk("halt_h", int'(galvoh), 1);
    chk("halt_spi", int'(spi_start), 0);

    // continuous 2x1: restart on the frame_done cycle
    setup(2, 1, 1, 1);
    to_idle(); auto_en = 1;
    tick(); start = 1;
    k = 0;
    do begin tick(); k++; end while (!frame_done && k < 200);
    chk("cont_fd", int'(frame_done), 1);
    chk("cont_spi", int'(spi_start), 1);
    chk("cont_pos", int'(galvoh) + int'(galvov), 0);
    cont = 0;

    // zero width: every go is a new line
    setup(0, 3, 0, 0);
    to_idle(); clr_cnt(); auto_en = 1;
    run_frame("h0");
    chk("h0_ld", n_ld, 3);
    chk("h0_spi", n_spi, 3);
    chk("h0_maxh", max_h, 0);

    // reset mid-SPI at (1,0)
    setup(3, 2, 0, 0);
    to_idle();
    tick(); start = 1;
    tick(); spi_done = 1;
    tick(); galvo_go = 1;
    tick();
    #2 rst = 1;
    #1;
    chk("arst_state", int'(scan_state), 0);
    chk("arst_outs", int'({galvoh, galvov, spi_start, settled,
        busy, line_done, frame_done, overrun}), 0);
    tick(); rst = 0;
    tick(); spi_done = 1;
    tick();
    chk("arst_done_ign", int'(scan_state), 0);
    start = 1;
    tick();
    chk("post_rst_start", int'(scan_state), 1);

    // randomized scan traffic
    to_idle(); auto_en = 1;
    for (int n = 0; n < 4000; n++) begin
      tick();
      if (m_mode == 0 && $urandom_range(0, 7) == 0) begin
        setup($urandom_range(0, 4), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1));
        done_dly = $urandom_range(1, 5);
        go_dly = $urandom_range(1, 4);
        start = 1;
      end
      if ($urandom_range(0, 40) == 0) begin
        h_size = 11'($urandom_range(0, 5));
        start = 1;
      end
      if ($urandom_range(0, 22) == 0) galvo_go = 1;
      if ($urandom_range(0, 36) == 0) spi_done = 1;
      if ($urandom_range(0, 96) == 0) halt = 1;
      if ($urandom_range(0, 60) == 0) cont = ~cont;
    end
    to_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
